laser_job_sched: RTL and testbench

LASER_JOB_SCHED -- requirements
Module: laser_job_sched

---
 rtl/laser_job_sched.sv | 146 ++++++++++++++
 tb/tb_laser_job_sched.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/laser_job_sched.sv
// laser_job_sched: two-requester job scheduler for the laser search engine.
// Buffers 40 points, streams them to the engine, then returns the result or a timeout error.
// Ports:
//   CLK, RST_N            clock, async active-low reset
//   REQ_VALID/REQ_READY   per-requester point handshake
//   REQ_X0/Y0, REQ_X1/Y1  requester points
//   ENG_RST, ENG_X/Y      engine reset and point stream
//   ENG_DONE, ENG_C*      engine result
//   RSP_*                 result handshake {C2Y,C2X,C1Y,C1X}, id, error
//   BUSY                  high whenever not idle
module laser_job_sched #(
  parameter logic [19:0] TIMEOUT = 20'd40000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [1:0]  REQ_VALID,
  output logic [1:0]  REQ_READY,
  input  logic [3:0]  REQ_X0,
  input  logic [3:0]  REQ_Y0,
  input  logic [3:0]  REQ_X1,
  input  logic [3:0]  REQ_Y1,
  output logic        ENG_RST,
  output logic [3:0]  ENG_X,
  output logic [3:0]  ENG_Y,
  input  logic        ENG_DONE,
  input  logic [3:0]  ENG_C1X,
  input  logic [3:0]  ENG_C1Y,
  input  logic [3:0]  ENG_C2X,
  input  logic [3:0]  ENG_C2Y,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic        RSP_ID,
  output logic        RSP_ERR,
  output logic [15:0] RSP_C,
  output logic        BUSY
);

  typedef enum logic [2:0] {
    IDLE, LOAD, FEED, WAIT, RESP
  } state_t;

  state_t      state, nxt;
  logic        grant, last;
  logic [5:0]  idx;
  logic [19:0] cnt, cnt_inc;
  logic [7:0]  pbuf [40];
  logic [7:0]  acc_pt;
  logic        acc, last_idx, expire, pick;

  assign acc      = (state == LOAD) && REQ_VALID[grant];
  assign last_idx = (idx == 6'd39);
  assign expire   = (cnt >= TIMEOUT - 20'd1);
  assign cnt_inc  = (&cnt) ? cnt : cnt + 20'd1;
  assign acc_pt   = grant ? {REQ_X1, REQ_Y1}
                          : {REQ_X0, REQ_Y0};
  // on a tie the requester not served last wins
  assign pick     = (REQ_VALID == 2'b11) ? ~last
                                         : REQ_VALID[1];
  assign RSP_ID   = grant;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt       = state;
    REQ_READY = 2'b00;
    ENG_RST   = 1'b1;
    ENG_X     = 4'h0;
    ENG_Y     = 4'h0;
    RSP_VALID = 1'b0;
    BUSY      = 1'b1;
    unique case (state)
      IDLE: begin
        BUSY = 1'b0;
        if (|REQ_VALID) nxt = LOAD;
      end
      LOAD: begin
        REQ_READY = grant ? 2'b10 : 2'b01;
        if (acc && last_idx) nxt = FEED;
      end
      FEED: begin
        ENG_RST = 1'b0;
        ENG_X   = pbuf[idx][7:4];
        ENG_Y   = pbuf[idx][3:0];
        if (last_idx) nxt = WAIT;
      end
      WAIT: begin
        ENG_RST = 1'b0;
        if (ENG_DONE || expire) nxt = RESP;
      end
      RESP: begin
        RSP_VALID = 1'b1;
        if (RSP_READY) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      grant   <= 1'b0;
      last    <= 1'b1;
      idx     <= 6'd0;
      cnt     <= 20'd0;
      RSP_C   <= 16'h0;
      RSP_ERR <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (|REQ_VALID) begin
          grant <= pick;
          idx   <= 6'd0;
        end
        LOAD: if (acc) begin
          idx <= last_idx ? 6'd0 : idx + 6'd1;
          if (last_idx) cnt <= 20'd0;
        end
        FEED: begin
          idx <= idx + 6'd1;
          cnt <= cnt_inc;
        end
        WAIT: begin
          cnt <= cnt_inc;
          // a result arriving on the expiry cycle still counts
          if (ENG_DONE) begin
            RSP_C   <= {ENG_C2Y, ENG_C2X,
                        ENG_C1Y, ENG_C1X};
            RSP_ERR <= 1'b0;
          end else if (expire) begin
            RSP_C   <= 16'h0;
            RSP_ERR <= 1'b1;
          end
        end
        RESP: if (RSP_READY) last <= grant;
        default: ;
      endcase
    end
  end

  // point buffer needs no reset: every job rewrites all 40 entries
  always_ff @(posedge CLK) begin
    if (acc) pbuf[idx] <= acc_pt;
  end

endmodule

// File: tb/tb_laser_job_sched.sv
// tb_laser_job_sched: directed bench for laser_job_sched.
// Drives requesters and an engine model, checks grants, stream, result and reset.
module tb_laser_job_sched;

  localparam logic [19:0] TO = 20'd100;

  logic        CLK, RST_N;
  logic [1:0]  REQ_VALID, REQ_READY;
  logic [3:0]  REQ_X0, REQ_Y0, REQ_X1, REQ_Y1;
  logic        ENG_RST, ENG_DONE;
  logic [3:0]  ENG_X, ENG_Y;
  logic [3:0]  ENG_C1X, ENG_C1Y, ENG_C2X, ENG_C2Y;
  logic        RSP_VALID, RSP_READY, RSP_ID, RSP_ERR;
  logic [15:0] RSP_C;
  logic        BUSY;

  logic [15:0] eng_c;
  logic [1:0]  want;
  int          pc[2];
  int          nvec = 0;
  int          nerr = 0;

  assign ENG_C1X = eng_c[3:0];
  assign ENG_C1Y = eng_c[7:4];
  assign ENG_C2X = eng_c[11:8];
  assign ENG_C2Y = eng_c[15:12];

  laser_job_sched #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_X0(REQ_X0), .REQ_Y0(REQ_Y0),
    .REQ_X1(REQ_X1), .REQ_Y1(REQ_Y1),
    .ENG_RST(ENG_RST), .ENG_X(ENG_X), .ENG_Y(ENG_Y),
    .ENG_DONE(ENG_DONE),
    .ENG_C1X(ENG_C1X), .ENG_C1Y(ENG_C1Y),
    .ENG_C2X(ENG_C2X), .ENG_C2Y(ENG_C2Y),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
    .RSP_ID(RSP_ID), .RSP_ERR(RSP_ERR),
    .RSP_C(RSP_C), .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // point k of requester r, packed {x,y}
  function automatic logic [7:0] pt(input int r,
                                    input int k);
    return 8'(k * 37 + r * 91 + 5);
  endfunction

  task automatic drive();
    REQ_VALID        = want;
    {REQ_X0, REQ_Y0} = pt(0, pc[0]);
    {REQ_X1, REQ_Y1} = pt(1, pc[1]);
  endtask

  // one clock; requesters advance on handshake
  task automatic cyc();
    logic [1:0] h;
    h = REQ_VALID & REQ_READY;
    @(posedge CLK);
    #1;
    if (h[0]) pc[0]++;
    if (h[1]) pc[1]++;
    drive();
  endtask

  task automatic chk_reset(input string tag);
    chk(tag, 32'({REQ_READY, ENG_RST, ENG_X, ENG_Y,
                  RSP_VALID, RSP_ID, RSP_ERR,
                  RSP_C, BUSY}),
        32'({2'b00, 1'b1, 4'h0, 4'h0,
             1'b0, 1'b0, 1'b0, 16'h0, 1'b0}));
  endtask

  task automatic rst();
    RST_N     = 1'b0;
    want      = 2'b00;
    ENG_DONE  = 1'b0;
    RSP_READY = 1'b0;
    drive();
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  // dly < 0: engine never answers; abort_at >= 0: reset in that FEED cycle
  task automatic run_job(input int who,
                         input int stall,
                         input int dly,
                         input logic [15:0] c,
                         input int hold,
                         input int abort_at,
                         input bit keep);
    int          base, t, n;
    logic [15:0] ec;
    logic        ee;
    want[who] = 1'b1;
    drive();
    cyc();
    chk("grant", 32'(REQ_READY), 32'(1) << who);
    base = pc[who];
    for (int k = 0; k < 40; k++) begin
      if (k == 21 && stall > 0) begin
        want[who] = 1'b0;
        drive();
        repeat (stall) cyc();
        chk("stall_hold",
            32'({BUSY, ENG_RST, REQ_READY}),
            32'({1'b1, 1'b1, 2'(1 << who)}));
        want[who] = 1'b1;
        drive();
      end
      t = 0;
      while (!REQ_READY[who] && t < 20) begin
        cyc();
        t++;
      end
      if (t == 20) begin
        chk("load_ready", 32'(REQ_READY[who]), 32'(1));
        return;
      end
      cyc();
    end
    if (!keep) begin
      want[who] = 1'b0;
      drive();
    end
    chk("feed_rst", 32'(ENG_RST), 32'(0));
    for (int k = 0; k < 40; k++) begin
      if (k == abort_at) begin
        #3 RST_N = 1'b0;
        #1 chk_reset("abort_reset");
        return;
      end
      if (k == 10) begin
        ENG_DONE = 1'b1;
        eng_c    = 16'hFFFF;
      end
      if (k == 11) ENG_DONE = 1'b0;
      chk("feed_pt", 32'({ENG_X, ENG_Y}),
          32'(pt(who, base + k)));
      cyc();
    end
    ENG_DONE = 1'b0;
    n = 40;
    chk("wait_out", 32'({ENG_RST, ENG_X, ENG_Y}), 32'(0));
    eng_c = c;
    if (dly >= 0) begin
      repeat (dly) begin
        cyc();
        n++;
      end
      chk("wait_busy", 32'(RSP_VALID), 32'(0));
      ENG_DONE = 1'b1;
      cyc();
      ENG_DONE = 1'b0;
      ec = c;
      ee = 1'b0;
    end else begin
      while (!RSP_VALID && n < 300) begin
        cyc();
        n++;
      end
      chk("timeout_cyc", 32'(n), 32'(TO));
      ec = 16'h0;
      ee = 1'b1;
    end
    chk("rsp", 32'({RSP_VALID, RSP_ID, RSP_ERR, RSP_C}),
        32'({1'b1, 1'(who), ee, ec}));
    chk("rsp_rst", 32'(ENG_RST), 32'(1));
    if (hold > 0) begin
      repeat (hold) cyc();
      chk("rsp_hold",
          32'({RSP_VALID, RSP_ID, RSP_ERR, RSP_C,
               ENG_RST, REQ_READY}),
          32'({1'b1, 1'(who), ee, ec, 1'b1, 2'b00}));
    end
    RSP_READY = 1'b1;
    cyc();
    RSP_READY = 1'b0;
    chk("idle", 32'({BUSY, ENG_RST, RSP_VALID}),
        32'(3'b010));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1);
  end

  initial begin
    RST_N     = 1'b0;
    want      = 2'b00;
    pc[0]     = 0;
    pc[1]     = 0;
    ENG_DONE  = 1'b0;
    eng_c     = 16'h0;
    RSP_READY = 1'b0;
    drive();
    #2 chk_reset("reset");

    // both requesters valid out of reset: 0,1,0,1
    want = 2'b11;
    drive();
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    run_job(0, 0, 5,  16'h1234, 0, -1, 1'b1);
    run_job(1, 0, 2,  16'h5678, 5, -1, 1'b1);
    run_job(0, 0, 0,  16'h9ABC, 0, -1, 1'b1);
    run_job(1, 0, 7,  16'hDEF0, 0, -1, 1'b1);

    // single job, stall, timeout, done on expiry
    rst();
    run_job(0, 0,  3,  16'h7A35, 0, -1, 1'b0);
    run_job(1, 10, 8,  16'hBEEF, 0, -1, 1'b0);
    run_job(0, 0,  -1, 16'h5555, 0, -1, 1'b0);
    run_job(1, 0,  59, 16'hC3A1, 0, -1, 1'b0);

    // reset in mid FEED, then recovery with a tie
    run_job(1, 0, 5, 16'h1111, 0, 15, 1'b0);
    want = 2'b11;
    drive();
    @(posedge CLK);
    #1 chk_reset("reset_held");
    RST_N = 1'b1;
    run_job(0, 0, 4, 16'h2468, 0, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
